ro_freq_meter: RTL and testbench

RO_FREQ_METER -- requirements
Module: ro_freq_meter

---
 rtl/ro_freq_meter.sv | 194 +++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter.
// The meter selects one of five oscillator outputs and enables the oscillator.
// It waits a fixed settle time, then counts synchronized rising edges over a
// programmable gate window. The result is offered with a valid/ready handshake.
module ro_freq_meter #(
  parameter int BITS   = 16,
  parameter int GATE_W = 16,
  parameter int SETTLE = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              meas_start,
  input  logic              meas_abort,
  input  logic [4:0]        cfg_sel,
  input  logic [2:0]        osc_idx,
  input  logic [GATE_W-1:0] gate_cycles,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              s4,
  output logic              s5,
  output logic              start,
  input  logic              X1_Y1,
  input  logic              X2_Y1,
  input  logic              X3_Y1,
  input  logic              X4_Y1,
  input  logic              X5_Y1,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [BITS-1:0]   count,
  output logic              overflow
);

  // One down-counter times both phases.
  // It is wide enough for the settle constant and for the gate length.
  localparam int TW = (GATE_W > 8) ? GATE_W : 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_DONE
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [TW-1:0]     timer_reg;
  logic [4:0]        cfg_reg;
  logic [2:0]        idx_reg;
  logic [GATE_W-1:0] gate_reg;
  logic [BITS-1:0]   count_reg;
  logic              ovf_reg;
  logic              sync1_reg;
  logic              sync2_reg;
  logic              hist_reg;

  logic              accept;
  logic              timer_zero;
  logic              edge_seen;
  logic              x_sel;
  logic [TW-1:0]     gate_last;

  assign timer_zero = (timer_reg == '0);
  // A gate length of zero is stretched to a single cycle.
  assign gate_last  = (gate_reg == '0) ? '0 : (TW'(gate_reg) - TW'(1));
  assign edge_seen  = sync2_reg & ~hist_reg;

  assign s1       = cfg_reg[0];
  assign s2       = cfg_reg[1];
  assign s3       = cfg_reg[2];
  assign s4       = cfg_reg[3];
  assign s5       = cfg_reg[4];
  assign count    = count_reg;
  assign overflow = ovf_reg;

  // Oscillator source mux; out-of-range indices read as a constant low input.
  always_comb begin
    x_sel = 1'b0;
    case (idx_reg)
      3'd0:    x_sel = X1_Y1;
      3'd1:    x_sel = X2_Y1;
      3'd2:    x_sel = X3_Y1;
      3'd3:    x_sel = X4_Y1;
      3'd4:    x_sel = X5_Y1;
      default: x_sel = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs; abort wins over timer expiry and the handshake.
  always_comb begin
    state_next   = state_reg;
    accept       = 1'b0;
    start        = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (meas_start) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        start = 1'b1;
        if (meas_abort)      state_next = ST_IDLE;
        else if (timer_zero) state_next = ST_GATE;
      end
      ST_GATE: begin
        start = 1'b1;
        if (meas_abort)      state_next = ST_IDLE;
        else if (timer_zero) state_next = ST_DONE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (meas_abort || result_ready) state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Phase timer.
  // It is loaded with the settle length on acceptance and with the gate length
  // when settling ends. It then counts down to zero.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      timer_reg <= '0;
    end else if (accept) begin
      timer_reg <= TW'(SETTLE - 1);
    end else if (state_reg == ST_SETTLE && timer_zero) begin
      timer_reg <= gate_last;
    end else if ((state_reg == ST_SETTLE || state_reg == ST_GATE) && !timer_zero) begin
      timer_reg <= timer_reg - TW'(1);
    end
  end

  // Measurement configuration is captured once per accepted request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cfg_reg  <= '0;
      idx_reg  <= '0;
      gate_reg <= '0;
    end else if (accept) begin
      cfg_reg  <= cfg_sel;
      idx_reg  <= osc_idx;
      gate_reg <= gate_cycles;
    end
  end

  // Free-running synchronizer plus history flop on the selected oscillator.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      hist_reg  <= 1'b0;
    end else begin
      sync1_reg <= x_sel;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  // Saturating edge counter with a sticky overflow flag.
  // Both are cleared only by a new acceptance.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (state_reg == ST_GATE && !meas_abort && edge_seen) begin
      if (count_reg == {BITS{1'b1}}) begin
        ovf_reg <= 1'b1;
      end else begin
        count_reg <= count_reg + BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Testbench for ro_freq_meter.
// Two instances share the same stimulus: one with a 16-bit counter and one with
// a 4-bit counter, so that saturation can be observed. Expected counts come from
// a log of the oscillator levels seen at each clock edge.
module tb_ro_freq_meter;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_start = 1'b0;
  logic        meas_abort = 1'b0;
  logic        result_ready = 1'b0;
  logic [4:0]  cfg_sel = '0;
  logic [2:0]  osc_idx = '0;
  logic [15:0] gate_cycles = '0;
  logic [4:0]  xs = '0;

  logic        s1, s2, s3, s4, s5, start, busy, result_valid, overflow;
  logic [15:0] count;
  logic        b_s1, b_s2, b_s3, b_s4, b_s5, b_start, b_busy, b_valid, b_ovf;
  logic [3:0]  b_count;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;
  logic [4:0] xlog [0:65535];
  int half_per [5];
  int hcnt [5];

  typedef struct {
    logic [4:0]  cfg;
    logic [2:0]  idx;
    logic [15:0] gate;
    int          half;
    int          rdly;
    int          lo;
    int          hi;
    int          lo4;
    int          hi4;
    logic        ovf4;
  } vec_t;

  vec_t tbl [7];

  ro_freq_meter #(.BITS(16), .GATE_W(16), .SETTLE(S)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .meas_start(meas_start), .meas_abort(meas_abort),
    .cfg_sel(cfg_sel), .osc_idx(osc_idx), .gate_cycles(gate_cycles),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .start(start),
    .X1_Y1(xs[0]), .X2_Y1(xs[1]), .X3_Y1(xs[2]), .X4_Y1(xs[3]), .X5_Y1(xs[4]),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .count(count), .overflow(overflow)
  );

  ro_freq_meter #(.BITS(4), .GATE_W(16), .SETTLE(S)) dut4 (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .meas_start(meas_start), .meas_abort(meas_abort),
    .cfg_sel(cfg_sel), .osc_idx(osc_idx), .gate_cycles(gate_cycles),
    .s1(b_s1), .s2(b_s2), .s3(b_s3), .s4(b_s4), .s5(b_s5), .start(b_start),
    .X1_Y1(xs[0]), .X2_Y1(xs[1]), .X3_Y1(xs[2]), .X4_Y1(xs[3]), .X5_Y1(xs[4]),
    .busy(b_busy), .result_valid(b_valid), .result_ready(result_ready),
    .count(b_count), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  // Oscillator models: each output toggles every half_per clocks (0 = frozen).
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (half_per[i] > 0) begin
        if (hcnt[i] + 1 >= half_per[i]) begin
          xs[i]   <= ~xs[i];
          hcnt[i] <= 0;
        end else begin
          hcnt[i] <= hcnt[i] + 1;
        end
      end
    end
  end

  // Record the oscillator levels present at every rising clock edge.
  always @(posedge clk) begin
    xlog[edge_no[15:0]] <= xs;
    edge_no <= edge_no + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run exceeded time limit, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_main"}, {s5, s4, s3, s2, s1, start, busy, result_valid, overflow, count}, 64'd0);
    chk({tag, "_bits4"}, {b_s5, b_s4, b_s3, b_s2, b_s1, b_start, b_busy, b_valid, b_ovf, b_count}, 64'd0);
  endtask

  function automatic logic sel_x(input int n, input logic [2:0] idx);
    logic [4:0] v;
    v = xlog[n[15:0]];
    if (idx > 3'd4) return 1'b0;
    return v[idx];
  endfunction

  // Edges counted during the gate.
  // The gate sees the oscillator two clocks late because of the synchronizer.
  // A rise is a 0 on the sample before and a 1 on the sample after.
  function automatic int model_raw(input int a, input logic [2:0] idx, input logic [15:0] g);
    int gl;
    int n;
    gl = (g == 16'd0) ? 1 : int'(g);
    n = 0;
    for (int e = a + S + 1; e <= a + S + gl; e++) begin
      if (sel_x(e - 2, idx) && !sel_x(e - 3, idx)) n++;
    end
    return n;
  endfunction

  task automatic set_osc(input logic [2:0] idx, input int half);
    for (int j = 0; j < 5; j++) half_per[j] = (j == int'(idx)) ? half : 2 + 2 * j;
  endtask

  task automatic run_meas(input string tag, input logic [4:0] cfg, input logic [2:0] idx,
                          input logic [15:0] g, input int rdly, input int lo, input int hi,
                          input int lo4, input int hi4, input logic ovf4, input logic ab);
    int a, n, st, raw, e16, e4, gl;
    logic [15:0] cnt_hold;
    logic [3:0]  cnt4_hold;
    gl = (g == 16'd0) ? 1 : int'(g);
    @(negedge clk);
    cfg_sel = cfg; osc_idx = idx; gate_cycles = g; meas_start = 1'b1; meas_abort = ab;
    @(posedge clk);
    a = edge_no;
    @(negedge clk);
    meas_start = 1'b0; meas_abort = 1'b0;
    cfg_sel = ~cfg; osc_idx = idx ^ 3'd3; gate_cycles = g ^ 16'h0055;
    chk({tag, "_sel"}, {s5, s4, s3, s2, s1}, cfg);
    chk({tag, "_busy"}, {busy, b_busy, start}, 3'b111);
    n = 0;
    st = 0;
    while (!result_valid && n < 4000) begin
      if (start) st++;
      meas_start = (n == 2 || n == S + 3);
      cfg_sel = 5'(n);
      @(negedge clk);
      n++;
    end
    meas_start = 1'b0;
    chk({tag, "_done_seen"}, n < 4000, 1'b1);
    chk({tag, "_start_cycles"}, st, S + gl);
    chk({tag, "_sel_hold"}, {s5, s4, s3, s2, s1}, cfg);
    raw = model_raw(a, idx, g);
    e16 = (raw > 65535) ? 65535 : raw;
    e4  = (raw > 15) ? 15 : raw;
    chk({tag, "_count"}, {overflow, count}, {raw > 65535, 16'(e16)});
    chk({tag, "_count4"}, {b_valid, b_ovf, b_count}, {1'b1, raw > 15, 4'(e4)});
    if (hi >= 0) begin
      chk({tag, "_range"}, (int'(count) >= lo) && (int'(count) <= hi), 1'b1);
      chk({tag, "_range4"}, {(int'(b_count) >= lo4) && (int'(b_count) <= hi4), b_ovf}, {1'b1, ovf4});
    end
    cnt_hold  = count;
    cnt4_hold = b_count;
    for (int k = 0; k < rdly; k++) begin
      @(negedge clk);
      chk({tag, "_stable"}, {result_valid, overflow, count, b_count}, {1'b1, raw > 65535, cnt_hold, cnt4_hold});
    end
    result_ready = 1'b1;
    meas_start = 1'b1;
    cfg_sel = 5'b11111;
    @(negedge clk);
    result_ready = 1'b0;
    meas_start = 1'b0;
    chk({tag, "_idle"}, {busy, result_valid, start, b_busy, b_valid}, 5'b0);
    chk({tag, "_retain"}, {s5, s4, s3, s2, s1, count, b_count}, {cfg, cnt_hold, cnt4_hold});
    $display("meas %s idx=%0d gate=%0d count=%0d ovf=%0b count4=%0d ovf4=%0b model=%0d",
             tag, idx, g, count, overflow, b_count, b_ovf, raw);
  endtask

  initial begin
    int a, seen;
    logic ovf4_pre;
    logic [15:0] cnt_after;

    tbl[0] = '{5'b10110, 3'd2, 16'd100, 5, 20, 9, 11, 9, 11, 1'b0};
    tbl[1] = '{5'b00001, 3'd0, 16'd200, 2, 1, 49, 51, 15, 15, 1'b1};
    tbl[2] = '{5'b11000, 3'd6, 16'd50, 1, 0, 0, 0, 0, 0, 1'b0};
    tbl[3] = '{5'b01101, 3'd4, 16'd0, 3, 2, 0, 1, 0, 1, 1'b0};
    tbl[4] = '{5'b10011, 3'd1, 16'd40, 0, 0, 0, 0, 0, 0, 1'b0};
    tbl[5] = '{5'b00100, 3'd3, 16'd255, 1, 3, 126, 129, 15, 15, 1'b1};
    tbl[6] = '{5'b11110, 3'd2, 16'd1, 7, 0, 0, 1, 0, 1, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      set_osc(tbl[i].idx, tbl[i].half);
      run_meas($sformatf("vec%0d", i), tbl[i].cfg, tbl[i].idx, tbl[i].gate, tbl[i].rdly,
               tbl[i].lo, tbl[i].hi, tbl[i].lo4, tbl[i].hi4, tbl[i].ovf4, 1'b0);
    end

    // Randomized measurements; the first one also asserts abort while in IDLE.
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 5; j++) half_per[j] = $urandom_range(0, 12);
      run_meas($sformatf("rnd%0d", i), 5'($urandom), 3'($urandom_range(0, 7)),
               16'($urandom_range(0, 300)), $urandom_range(0, 4), 0, -1, 0, 0, 1'b0, i == 0);
    end

    // Abort during the 50th gate cycle.
    set_osc(3'd2, 1);
    @(negedge clk);
    cfg_sel = 5'b01010; osc_idx = 3'd2; gate_cycles = 16'd200; meas_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    meas_start = 1'b0;
    repeat (S + 49) @(negedge clk);
    ovf4_pre = b_ovf;
    chk("abort_pre_ovf4", ovf4_pre, 1'b1);
    meas_abort = 1'b1;
    @(negedge clk);
    meas_abort = 1'b0;
    chk("abort_idle", {start, busy, result_valid, b_start, b_busy, b_valid}, 6'b0);
    chk("abort_ovf", {overflow, b_ovf}, {1'b0, ovf4_pre});
    cnt_after = count;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (result_valid || b_valid || busy || count != cnt_after) seen = 1;
    end
    chk("abort_quiet", seen, 0);
    $display("abort count=%0d count4=%0d ovf4=%0b", count, b_count, b_ovf);

    // Reset pulse in the middle of the gate.
    @(negedge clk);
    cfg_sel = 5'b00111; osc_idx = 3'd2; gate_cycles = 16'd200; meas_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    meas_start = 1'b0;
    repeat (S + 20) @(negedge clk);
    chk("rst_pre_busy", {busy, start}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (result_valid || b_valid || busy) seen = 1;
    end
    chk("rst_no_result", seen, 0);
    $display("reset mid-gate busy=%0b valid=%0b", busy, result_valid);

    // Second short reset, released just before a request that must be taken at the first edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("rst2_async");
    #1 rst_n = 1'b1;
    set_osc(3'd1, 4);
    run_meas("post_rst", 5'b10001, 3'd1, 16'd60, 1, 6, 9, 6, 9, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
